// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch conditions
// and the "no register" address.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRA = 3'd5,
    ALU_SLT = 3'd6,
    ALU_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_BEQZ  = 4'd0,
    BR_BNEZ  = 4'd1,
    BR_BTEQZ = 4'd2,
    BR_B     = 4'd3
  } br_cond_e;

  localparam logic [3:0] NOREG = 4'hF;

endpackage

// File: rtl/alu16.sv
// Combinational ALU of the execute stage. Shift amounts come from b[3:0],
// where an amount of zero encodes a shift by eight.
module alu16
  import ex_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] result
);

  logic [3:0] shamt;

  assign shamt = (b[3:0] == 4'd0) ? 4'd8 : b[3:0];

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_CMP: result = {{(W-1){1'b0}}, (a != b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, operand-B select, ALU, branch resolution, the
// T flag and the EX/MEM pipeline register.
module ex_stage #(
  parameter int         W     = 16,
  parameter logic [3:0] NOREG = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] id_pc,
  input  logic [W-1:0] id_rdata1,
  input  logic [W-1:0] id_rdata2,
  input  logic [3:0]   id_raddr1,
  input  logic [3:0]   id_raddr2,
  input  logic [3:0]   id_waddr,
  input  logic [3:0]   id_imm,
  input  logic [3:0]   id_opcode,
  input  logic [7:0]   id_immed,
  input  logic [2:0]   id_aluop,
  input  logic [1:0]   id_wdata_sel1,
  input  logic         id_wdata_sel2,
  input  logic         id_bsel,
  input  logic         id_immed_sel,
  input  logic         id_modify,
  input  logic         id_dm_wen,
  input  logic         id_exe,
  input  logic         id_rf_wen,
  input  logic         id_postflush,
  input  logic         id_poststall,
  input  logic         mem_stall,
  input  logic         wb_rf_wen,
  input  logic [3:0]   wb_waddr,
  input  logic [W-1:0] wb_wdata,
  output logic         branch_taken,
  output logic [W-1:0] branch_target,
  output logic         t_flag,
  output logic [W-1:0] exmem_pc,
  output logic [W-1:0] exmem_alu,
  output logic [W-1:0] exmem_sdata,
  output logic [3:0]   exmem_waddr,
  output logic [1:0]   exmem_wdata_sel1,
  output logic         exmem_wdata_sel2,
  output logic         exmem_rf_wen,
  output logic         exmem_dm_wen
);

  import ex_pkg::*;

  logic         valid;
  logic [W-1:0] fwd_a, fwd_b, op_b, alu_result, immed_sext;
  logic         cond;

  logic         t_d, t_q;
  logic [W-1:0] exmem_pc_d, exmem_pc_q;
  logic [W-1:0] exmem_alu_d, exmem_alu_q;
  logic [W-1:0] exmem_sdata_d, exmem_sdata_q;
  logic [3:0]   exmem_waddr_d, exmem_waddr_q;
  logic [1:0]   exmem_wdata_sel1_d, exmem_wdata_sel1_q;
  logic         exmem_wdata_sel2_d, exmem_wdata_sel2_q;
  logic         exmem_rf_wen_d, exmem_rf_wen_q;
  logic         exmem_dm_wen_d, exmem_dm_wen_q;

  assign valid      = !id_postflush && !id_poststall;
  assign immed_sext = {{(W-8){id_immed[7]}}, id_immed};

  // The EX/MEM result is younger than WB, so it wins when both match.
  always_comb begin
    fwd_a = id_rdata1;
    if (exmem_rf_wen_q && exmem_waddr_q == id_raddr1 && id_raddr1 != NOREG)
      fwd_a = exmem_alu_q;
    else if (wb_rf_wen && wb_waddr == id_raddr1 && id_raddr1 != NOREG)
      fwd_a = wb_wdata;

    fwd_b = id_rdata2;
    if (exmem_rf_wen_q && exmem_waddr_q == id_raddr2 && id_raddr2 != NOREG)
      fwd_b = exmem_alu_q;
    else if (wb_rf_wen && wb_waddr == id_raddr2 && id_raddr2 != NOREG)
      fwd_b = wb_wdata;

    if (id_immed_sel)  op_b = immed_sext;
    else if (id_bsel)  op_b = {{(W-4){1'b0}}, id_imm};
    else               op_b = fwd_b;
  end

  alu16 #(.W(W)) u_alu (
    .a      (fwd_a),
    .b      (op_b),
    .op     (alu_op_e'(id_aluop)),
    .result (alu_result)
  );

  // BTEQZ looks at the stored T, not at a flag this same instruction sets.
  always_comb begin
    cond = 1'b0;
    case (id_opcode)
      BR_BEQZ:  cond = (fwd_a == '0);
      BR_BNEZ:  cond = (fwd_a != '0);
      BR_BTEQZ: cond = !t_q;
      BR_B:     cond = 1'b1;
      default:  cond = 1'b0;
    endcase
  end

  assign branch_taken  = valid && id_exe && cond;
  assign branch_target = id_pc + immed_sext;

  // T updates independently of mem_stall; EX/MEM holds while stalled.
  always_comb begin
    t_d                = t_q;
    exmem_pc_d         = exmem_pc_q;
    exmem_alu_d        = exmem_alu_q;
    exmem_sdata_d      = exmem_sdata_q;
    exmem_waddr_d      = exmem_waddr_q;
    exmem_wdata_sel1_d = exmem_wdata_sel1_q;
    exmem_wdata_sel2_d = exmem_wdata_sel2_q;
    exmem_rf_wen_d     = exmem_rf_wen_q;
    exmem_dm_wen_d     = exmem_dm_wen_q;
    if (valid && id_modify) t_d = (alu_result != '0);
    if (!mem_stall) begin
      exmem_pc_d         = id_pc;
      exmem_alu_d        = alu_result;
      exmem_sdata_d      = fwd_b;
      exmem_waddr_d      = id_waddr;
      exmem_wdata_sel1_d = id_wdata_sel1;
      exmem_wdata_sel2_d = id_wdata_sel2;
      exmem_rf_wen_d     = id_rf_wen && valid;
      exmem_dm_wen_d     = id_dm_wen && valid;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q                <= 1'b0;
      exmem_pc_q         <= '0;
      exmem_alu_q        <= '0;
      exmem_sdata_q      <= '0;
      exmem_waddr_q      <= '0;
      exmem_wdata_sel1_q <= '0;
      exmem_wdata_sel2_q <= 1'b0;
      exmem_rf_wen_q     <= 1'b0;
      exmem_dm_wen_q     <= 1'b0;
    end else begin
      t_q                <= t_d;
      exmem_pc_q         <= exmem_pc_d;
      exmem_alu_q        <= exmem_alu_d;
      exmem_sdata_q      <= exmem_sdata_d;
      exmem_waddr_q      <= exmem_waddr_d;
      exmem_wdata_sel1_q <= exmem_wdata_sel1_d;
      exmem_wdata_sel2_q <= exmem_wdata_sel2_d;
      exmem_rf_wen_q     <= exmem_rf_wen_d;
      exmem_dm_wen_q     <= exmem_dm_wen_d;
    end
  end

  assign t_flag           = t_q;
  assign exmem_pc         = exmem_pc_q;
  assign exmem_alu        = exmem_alu_q;
  assign exmem_sdata      = exmem_sdata_q;
  assign exmem_waddr      = exmem_waddr_q;
  assign exmem_wdata_sel1 = exmem_wdata_sel1_q;
  assign exmem_wdata_sel2 = exmem_wdata_sel2_q;
  assign exmem_rf_wen     = exmem_rf_wen_q;
  assign exmem_dm_wen     = exmem_dm_wen_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// instructions, all compared against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_pc, id_rdata1, id_rdata2;
  logic [3:0]  id_raddr1, id_raddr2, id_waddr, id_imm, id_opcode;
  logic [7:0]  id_immed;
  logic [2:0]  id_aluop;
  logic [1:0]  id_wdata_sel1;
  logic        id_wdata_sel2, id_bsel, id_immed_sel, id_modify, id_dm_wen;
  logic        id_exe, id_rf_wen, id_postflush, id_poststall, mem_stall;
  logic        wb_rf_wen;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;
  logic        branch_taken, t_flag;
  logic [15:0] branch_target, exmem_pc, exmem_alu, exmem_sdata;
  logic [3:0]  exmem_waddr;
  logic [1:0]  exmem_wdata_sel1;
  logic        exmem_wdata_sel2, exmem_rf_wen, exmem_dm_wen;

  int tests = 0;
  int fails = 0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_waddr(id_waddr),
    .id_imm(id_imm), .id_opcode(id_opcode), .id_immed(id_immed),
    .id_aluop(id_aluop), .id_wdata_sel1(id_wdata_sel1),
    .id_wdata_sel2(id_wdata_sel2), .id_bsel(id_bsel),
    .id_immed_sel(id_immed_sel), .id_modify(id_modify),
    .id_dm_wen(id_dm_wen), .id_exe(id_exe), .id_rf_wen(id_rf_wen),
    .id_postflush(id_postflush), .id_poststall(id_poststall),
    .mem_stall(mem_stall), .wb_rf_wen(wb_rf_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .t_flag(t_flag),
    .exmem_pc(exmem_pc), .exmem_alu(exmem_alu), .exmem_sdata(exmem_sdata),
    .exmem_waddr(exmem_waddr), .exmem_wdata_sel1(exmem_wdata_sel1),
    .exmem_wdata_sel2(exmem_wdata_sel2), .exmem_rf_wen(exmem_rf_wen),
    .exmem_dm_wen(exmem_dm_wen)
  );

  always #5 clk = ~clk;

  // Reference model state: what EX/MEM and T should hold.
  logic        m_t, m_sel2, m_rfw, m_dmw;
  logic [15:0] m_pc, m_alu, m_sdata;
  logic [3:0]  m_waddr;
  logic [1:0]  m_sel1;
  logic [15:0] exp_a, exp_fb, exp_b, exp_alu, exp_target;
  logic        exp_taken, exp_valid;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] ra, input logic [15:0] rd);
    if (m_rfw && m_waddr == ra && ra != 4'hF) return m_alu;
    if (wb_rf_wen && wb_waddr == ra && ra != 4'hF) return wb_wdata;
    return rd;
  endfunction

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
    int sh, pw, sa, r;
    sh = b % 16;
    if (sh == 0) sh = 8;
    pw = 1 << sh;
    sa = to_signed(a);
    case (op)
      0: r = a + b;
      1: r = a - b + 65536;
      2: r = a & b;
      3: r = a | b;
      4: r = a * pw;
      5: r = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw);
      6: r = (sa < to_signed(b)) ? 1 : 0;
      default: r = (a != b) ? 1 : 0;
    endcase
    return 16'(r & 32'hFFFF);
  endfunction

  task automatic model_eval();
    int imm_s;
    exp_valid = !id_postflush && !id_poststall;
    exp_a  = fwd(id_raddr1, id_rdata1);
    exp_fb = fwd(id_raddr2, id_rdata2);
    imm_s  = to_signed({24'd0, id_immed} * 256) / 256;
    if (id_immed_sel) exp_b = 16'(imm_s & 32'hFFFF);
    else if (id_bsel) exp_b = {12'd0, id_imm};
    else              exp_b = exp_fb;
    exp_alu    = ref_alu(int'(id_aluop), int'(exp_a), int'(exp_b));
    exp_target = 16'((int'(id_pc) + imm_s + 65536) % 65536);
    case (int'(id_opcode))
      0: exp_taken = (exp_a == 16'd0);
      1: exp_taken = (exp_a != 16'd0);
      2: exp_taken = (m_t == 1'b0);
      3: exp_taken = 1'b1;
      default: exp_taken = 1'b0;
    endcase
    exp_taken = exp_taken && exp_valid && id_exe;
  endtask

  task automatic model_clock();
    if (rst) begin
      m_t = 0; m_pc = 0; m_alu = 0; m_sdata = 0; m_waddr = 0;
      m_sel1 = 0; m_sel2 = 0; m_rfw = 0; m_dmw = 0;
    end else begin
      if (exp_valid && id_modify) m_t = (exp_alu != 16'd0);
      if (!mem_stall) begin
        m_pc = id_pc; m_alu = exp_alu; m_sdata = exp_fb; m_waddr = id_waddr;
        m_sel1 = id_wdata_sel1; m_sel2 = id_wdata_sel2;
        m_rfw = id_rf_wen && exp_valid; m_dmw = id_dm_wen && exp_valid;
      end
    end
  endtask

  // Inputs are driven just after a rising edge; one cycle is evaluated here.
  task automatic cycle();
    model_eval();
    #1;
    check("branch_taken", {15'd0, branch_taken}, {15'd0, exp_taken});
    if (exp_taken) check("branch_target", branch_target, exp_target);
    @(posedge clk);
    model_clock();
    #1;
    check("t_flag", {15'd0, t_flag}, {15'd0, m_t});
    check("exmem_pc", exmem_pc, m_pc);
    check("exmem_alu", exmem_alu, m_alu);
    check("exmem_sdata", exmem_sdata, m_sdata);
    check("exmem_waddr", {12'd0, exmem_waddr}, {12'd0, m_waddr});
    check("exmem_sel1", {14'd0, exmem_wdata_sel1}, {14'd0, m_sel1});
    check("exmem_sel2", {15'd0, exmem_wdata_sel2}, {15'd0, m_sel2});
    check("exmem_rf_wen", {15'd0, exmem_rf_wen}, {15'd0, m_rfw});
    check("exmem_dm_wen", {15'd0, exmem_dm_wen}, {15'd0, m_dmw});
  endtask

  task automatic idle();
    id_pc = 0; id_rdata1 = 0; id_rdata2 = 0;
    id_raddr1 = 4'hF; id_raddr2 = 4'hF; id_waddr = 0; id_imm = 0;
    id_opcode = 4'hF; id_immed = 0; id_aluop = 0; id_wdata_sel1 = 0;
    id_wdata_sel2 = 0; id_bsel = 0; id_immed_sel = 0; id_modify = 0;
    id_dm_wen = 0; id_exe = 0; id_rf_wen = 0; id_postflush = 0;
    id_poststall = 0; mem_stall = 0; wb_rf_wen = 0; wb_waddr = 0;
    wb_wdata = 0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_t"}, {15'd0, t_flag}, 16'd0);
    check({tag, "_alu"}, exmem_alu, 16'd0);
    check({tag, "_pc"}, exmem_pc, 16'd0);
    check({tag, "_waddr"}, {12'd0, exmem_waddr}, 16'd0);
    check({tag, "_rfw"}, {15'd0, exmem_rf_wen}, 16'd0);
  endtask

  initial begin
    idle();
    rst = 1;
    id_pc = 16'h1234; id_aluop = 3'd3; id_rdata1 = 16'h00F0; id_raddr1 = 4'd1;
    id_rf_wen = 1; id_waddr = 4'd9; id_modify = 1;
    cycle();
    cycle();
    check_cleared("reset");
    rst = 0;

    // ADD with sign-extended immediate: 5 + (-3)
    idle(); id_raddr1 = 1; id_rdata1 = 5; id_immed = 8'hFD; id_immed_sel = 1;
    id_rf_wen = 1; id_waddr = 2; id_pc = 16'h0100;
    cycle(); check("add_imm", exmem_alu, 16'd2);

    // r3 = 7, then a dependent read of r3 with stale register data
    idle(); id_raddr1 = 1; id_rdata1 = 7; id_immed_sel = 1; id_waddr = 3; id_rf_wen = 1;
    cycle();
    idle(); id_raddr1 = 3; id_rdata1 = 0; id_immed_sel = 1; id_waddr = 3; id_rf_wen = 1;
    cycle(); check("fwd_exmem", exmem_alu, 16'd7);
    idle(); wb_rf_wen = 1; wb_waddr = 3; wb_wdata = 16'h0055;
    id_raddr1 = 3; id_immed_sel = 1; id_waddr = 4; id_rf_wen = 1;
    cycle(); check("fwd_priority", exmem_alu, 16'd7);
    idle(); wb_rf_wen = 1; wb_waddr = 3; wb_wdata = 16'h0055;
    id_raddr1 = 3; id_immed_sel = 1;
    cycle(); check("fwd_wb", exmem_alu, 16'h0055);

    // NOREG never forwards, even when both sources target it
    idle(); id_raddr1 = 1; id_rdata1 = 16'h1234; id_immed_sel = 1; id_waddr = 4'hF; id_rf_wen = 1;
    cycle();
    idle(); wb_rf_wen = 1; wb_waddr = 4'hF; wb_wdata = 16'h0999;
    id_raddr1 = 4'hF; id_rdata1 = 16'h0042; id_immed_sel = 1;
    cycle(); check("noreg", exmem_alu, 16'h0042);

    idle(); id_aluop = 3'd5; id_raddr1 = 1; id_rdata1 = 16'h8000; id_bsel = 1; id_imm = 0;
    cycle(); check("sra_by8", exmem_alu, 16'hFF80);
    idle(); id_aluop = 3'd4; id_raddr1 = 1; id_rdata1 = 16'h0001; id_bsel = 1; id_imm = 4;
    cycle(); check("sll_by4", exmem_alu, 16'h0010);

    // CMP sets T=1 when unequal, then T=0 when equal
    idle(); id_aluop = 3'd7; id_raddr1 = 1; id_rdata1 = 3; id_raddr2 = 2; id_rdata2 = 4; id_modify = 1;
    cycle(); check("cmp_ne_t", {15'd0, t_flag}, 16'd1);
    idle(); id_aluop = 3'd7; id_raddr1 = 1; id_rdata1 = 3; id_raddr2 = 2; id_rdata2 = 3; id_modify = 1;
    cycle(); check("cmp_eq_t", {15'd0, t_flag}, 16'd0);

    idle(); id_exe = 1; id_opcode = 4'd2; id_pc = 16'h0010; id_immed = 8'hF0;
    id_rf_wen = 1; id_waddr = 5;
    #1;
    check("bteqz_taken", {15'd0, branch_taken}, 16'd1);
    check("bteqz_target", branch_target, 16'h0000);
    cycle();

    // Flushed copy: no branch, no write, T untouched despite nonzero CMP
    id_postflush = 1; id_aluop = 3'd7; id_raddr1 = 1; id_rdata1 = 3;
    id_raddr2 = 2; id_rdata2 = 4; id_modify = 1; id_dm_wen = 1;
    #1;
    check("flush_taken", {15'd0, branch_taken}, 16'd0);
    cycle();
    check("flush_rfw", {15'd0, exmem_rf_wen}, 16'd0);
    check("flush_dmw", {15'd0, exmem_dm_wen}, 16'd0);
    check("flush_t", {15'd0, t_flag}, 16'd0);

    // Stall holds EX/MEM for two cycles; reset mid-stall clears everything
    idle(); id_raddr1 = 1; id_rdata1 = 16'hAAAA; id_immed_sel = 1; id_modify = 1;
    id_rf_wen = 1; id_waddr = 6;
    cycle(); check("pre_stall", exmem_alu, 16'hAAAA);
    idle(); mem_stall = 1; id_raddr1 = 1; id_rdata1 = 16'h1111; id_immed_sel = 1;
    id_rf_wen = 1; id_waddr = 7;
    cycle(); check("stall1_alu", exmem_alu, 16'hAAAA);
    cycle(); check("stall2_waddr", {12'd0, exmem_waddr}, 16'd6);
    check("stall2_t", {15'd0, t_flag}, 16'd1);
    rst = 1;
    cycle();
    check_cleared("rst_stall");
    rst = 0;

    // Random instructions, small register range to exercise forwarding
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      id_pc         = 16'($urandom);
      id_rdata1     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      id_rdata2     = 16'($urandom);
      id_raddr1     = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      id_raddr2     = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      id_waddr      = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      id_imm        = 4'($urandom);
      id_opcode     = 4'($urandom_range(0, 5));
      id_immed      = 8'($urandom);
      id_aluop      = 3'($urandom);
      id_wdata_sel1 = 2'($urandom);
      id_wdata_sel2 = 1'($urandom);
      id_bsel       = 1'($urandom);
      id_immed_sel  = ($urandom_range(0, 3) == 0);
      id_modify     = 1'($urandom);
      id_dm_wen     = 1'($urandom);
      id_exe        = 1'($urandom);
      id_rf_wen     = 1'($urandom);
      id_postflush  = ($urandom_range(0, 3) == 0);
      id_poststall  = ($urandom_range(0, 5) == 0);
      mem_stall     = ($urandom_range(0, 3) == 0);
      wb_rf_wen     = 1'($urandom);
      wb_waddr      = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      wb_wdata      = 16'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
